// File: rtl/kbd_scan_encoder.sv
// ============================================================================
// kbd_scan_encoder
//
// Scans a 4x4 key matrix one column at a time, debounces a single key press
// and reports it as a 4-bit code with a one-cycle valid strobe, a held level
// and a running press count. Only one key is serviced at a time (no rollover).
//
// Parameters
//   SCAN_DIV         clocks each column is driven before its rows are sampled (>= 1)
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a press or a
//                    release (>= 1)
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   row_in     in   4  row sense lines (1 = contact on the driven column), pre-synchronised
//   col_out    out  4  one-hot column drive
//   key_code   out  4  {row_idx, col_idx} of the last accepted key
//   key_valid  out  1  one-cycle pulse when a press is accepted
//   key_held   out  1  high from press acceptance until release acceptance
//   key_count  out  8  accepted presses, modulo 256
// ============================================================================
module kbd_scan_encoder #(
    parameter int SCAN_DIV        = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] key_count
);

    // Dwell counter runs 0..SCAN_DIV-1; debounce counter runs 0..DEBOUNCE_CYCLES-1.
    // Acceptance fires on the edge where the counter *would* reach
    // DEBOUNCE_CYCLES, so the counter itself never has to hold that value.
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic [3:0]      r_col;
    logic [DW-1:0]   r_dwell;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_row_idx;
    logic [1:0]      r_col_idx;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_held;
    logic [7:0]      r_key_count;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [3:0]      w_col_nxt;
    logic [DW-1:0]   w_dwell_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      w_row_idx_nxt;
    logic [1:0]      w_col_idx_nxt;
    logic [3:0]      w_key_code_nxt;
    logic            w_key_valid_nxt;
    logic            w_key_held_nxt;
    logic [7:0]      w_key_count_nxt;

    logic [3:0]      w_col_adv;
    logic [1:0]      w_col_idx_cur;
    logic [1:0]      w_row_low;
    logic            w_row_any;
    logic            w_row_bit;

    // Column rotation 0001 -> 0010 -> 0100 -> 1000 -> 0001.
    assign w_col_adv = {r_col[2:0], r_col[3]};
    assign w_row_any = |row_in;
    // Only the captured row is watched once a key has been picked.
    assign w_row_bit = row_in[r_row_idx];

    // One-hot column to index.
    always_comb begin
        case (r_col)
            4'b0010: w_col_idx_cur = 2'd1;
            4'b0100: w_col_idx_cur = 2'd2;
            4'b1000: w_col_idx_cur = 2'd3;
            default: w_col_idx_cur = 2'd0;
        endcase
    end

    // Lowest set row wins when several rows close at once.
    always_comb begin
        if (row_in[0])      w_row_low = 2'd0;
        else if (row_in[1]) w_row_low = 2'd1;
        else if (row_in[2]) w_row_low = 2'd2;
        else                w_row_low = 2'd3;
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_dwell_nxt     = r_dwell;
        w_cnt_nxt       = r_cnt;
        w_row_idx_nxt   = r_row_idx;
        w_col_idx_nxt   = r_col_idx;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;          // strobe: high for one clock only
        w_key_held_nxt  = r_key_held;
        w_key_count_nxt = r_key_count;

        case (r_state)
            ST_SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_row_any) begin
                        // Freeze the column and remember where the contact is.
                        w_row_idx_nxt = w_row_low;
                        w_col_idx_nxt = w_col_idx_cur;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = ST_DEBOUNCE;
                    end else begin
                        w_col_nxt = w_col_adv;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (w_row_bit) begin
                    if (r_cnt == DEB_LAST) begin
                        w_key_code_nxt  = {r_row_idx, r_col_idx};
                        w_key_valid_nxt = 1'b1;
                        w_key_held_nxt  = 1'b1;
                        w_key_count_nxt = r_key_count + 8'd1;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = ST_HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    // Bounce: give up on this key and move on.
                    w_cnt_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_col_nxt   = w_col_adv;
                    w_state_nxt = ST_SCAN;
                end
            end

            ST_HELD: begin
                if (!w_row_bit) begin
                    if (r_cnt == DEB_LAST) begin
                        w_key_held_nxt = 1'b0;
                        w_cnt_nxt      = '0;
                        w_dwell_nxt    = '0;
                        w_col_nxt      = w_col_adv;
                        w_state_nxt    = ST_SCAN;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    // Any contact restarts the release count.
                    w_cnt_nxt = '0;
                end
            end

            default: begin
                // Unused encoding: fall back to scanning from column 0.
                w_state_nxt    = ST_SCAN;
                w_col_nxt      = 4'b0001;
                w_dwell_nxt    = '0;
                w_cnt_nxt      = '0;
                w_key_held_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_col       <= 4'b0001;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_row_idx   <= 2'd0;
            r_col_idx   <= 2'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_key_count <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_dwell     <= w_dwell_nxt;
            r_cnt       <= w_cnt_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
            r_key_count <= w_key_count_nxt;
        end
    end

    // All outputs come straight from registers.
    assign col_out   = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign key_count = r_key_count;

endmodule

// File: tb/tb_kbd_scan_encoder.sv
// ============================================================================
// tb_kbd_scan_encoder
//
// Directed testbench for kbd_scan_encoder with default parameters
// (SCAN_DIV=2, DEBOUNCE_CYCLES=4). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, away from the edge.
// ============================================================================
module tb_kbd_scan_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in = 4'b0000;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] key_count;

    int n_checks = 0;
    int n_fail   = 0;

    kbd_scan_encoder #(
        .SCAN_DIV        (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_count (key_count)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until col_out switches to target; we then sit at the first dwell clock.
    task automatic wait_col(input logic [3:0] target, input string tag);
        logic [3:0] prev;
        bit found;
        prev  = col_out;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            tick();
            if (col_out === target && prev !== target) found = 1'b1;
            prev = col_out;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s wait_col: col_out=%b never switched to %b", tag, col_out, target);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] exp_col;
        rst_n  = 1'b0;
        row_in = 4'b1111;
        tick(); tick(); tick();
        n_checks++; if (col_out !== 4'b0001) begin n_fail++; $display("FAIL reset col_out: got %b want 0001", col_out); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset key_code: got %b want 0000", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset key_valid: got %b want 0", key_valid); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset key_held: got %b want 0", key_held); end
        n_checks++; if (key_count !== 8'd0) begin n_fail++; $display("FAIL reset key_count: got %0d want 0", key_count); end
        rst_n  = 1'b1;
        row_in = 4'b0000;
        // Column index after n edges is (n/2) mod 4; back to 0001 after 8.
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_col = 4'b0001 << ((n / 2) % 4);
            n_checks++;
            if (col_out !== exp_col) begin
                n_fail++;
                $display("FAIL scan_rotation edge %0d: col_out got %b want %b", n, col_out, exp_col);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_clean_press();
        wait_col(4'b0010, "clean");
        row_in = 4'b0100;          // row 2, column 1
        tick(); tick();            // second dwell clock = capture edge E0
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL clean early_valid E%0d: got %b want 0", k, key_valid); end
            n_checks++; if (col_out !== 4'b0010) begin n_fail++; $display("FAIL clean col_frozen E%0d: got %b want 0010", k, col_out); end
        end
        tick();                    // E4
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL clean key_valid: got %b want 1", key_valid); end
        n_checks++; if (key_code !== 4'b1001) begin n_fail++; $display("FAIL clean key_code: got %b want 1001", key_code); end
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL clean key_held: got %b want 1", key_held); end
        n_checks++; if (key_count !== 8'd1) begin n_fail++; $display("FAIL clean key_count: got %0d want 1", key_count); end
        tick();
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL clean valid_width: got %b want 0", key_valid); end
        row_in = 4'b0000;
        tick(); tick(); tick();
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL clean held_3zeros: got %b want 1", key_held); end
        tick();
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL clean release_held: got %b want 0", key_held); end
        n_checks++; if (col_out !== 4'b0100) begin n_fail++; $display("FAIL clean resume_col: got %b want 0100", col_out); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bounce();
        wait_col(4'b1000, "bounce");
        row_in = 4'b0001;          // row 0, column 3
        tick(); tick();            // E0
        tick(); tick();            // two DEBOUNCE clocks
        row_in = 4'b0000;
        tick();
        n_checks++; if (col_out !== 4'b0001) begin n_fail++; $display("FAIL bounce resume_col: got %b want 0001", col_out); end
        n_checks++; if (key_code !== 4'b1001) begin n_fail++; $display("FAIL bounce key_code: got %b want 1001", key_code); end
        n_checks++; if (key_count !== 8'd1) begin n_fail++; $display("FAIL bounce key_count: got %0d want 1", key_count); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce key_held: got %b want 0", key_held); end
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL bounce no_valid %0d: got %b want 0", k, key_valid); end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_simultaneous();
        wait_col(4'b0001, "simul");
        row_in = 4'b1010;          // rows 1 and 3 on column 0
        tick(); tick();            // E0
        tick(); tick(); tick(); tick();
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL simul key_valid: got %b want 1", key_valid); end
        n_checks++; if (key_code !== 4'b0100) begin n_fail++; $display("FAIL simul key_code: got %b want 0100", key_code); end
        n_checks++; if (key_count !== 8'd2) begin n_fail++; $display("FAIL simul key_count: got %0d want 2", key_count); end
        row_in = 4'b1111;          // extra rows while held
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL simul extra_row_valid %0d: got %b want 0", k, key_valid); end
        end
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL simul key_held: got %b want 1", key_held); end
        n_checks++; if (key_code !== 4'b0100) begin n_fail++; $display("FAIL simul code_stable: got %b want 0100", key_code); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_release_bounce();
        row_in = 4'b1101;          // captured row 1 drops, others stay
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL relbounce held_low %0d: got %b want 1", k, key_held); end
        end
        row_in = 4'b1010;          // contact returns before the 4th zero
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (key_held !== 1'b1 || key_valid !== 1'b0) begin
                n_fail++; $display("FAIL relbounce restored %0d: held=%b valid=%b want held=1 valid=0", k, key_held, key_valid);
            end
        end
        row_in = 4'b0000;
        tick(); tick(); tick(); tick();
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL relbounce final_release: got %b want 0", key_held); end
        n_checks++; if (col_out !== 4'b0010) begin n_fail++; $display("FAIL relbounce resume_col: got %b want 0010", col_out); end
        n_checks++; if (key_count !== 8'd2) begin n_fail++; $display("FAIL relbounce key_count: got %0d want 2", key_count); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wrap();
        logic [7:0] exp_cnt;
        bit found;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (key_count !== 8'd0) begin n_fail++; $display("FAIL wrap start_count: got %0d want 0", key_count); end
        exp_cnt = 8'd0;
        for (int p = 0; p < 256; p++) begin
            row_in = 4'b0001;
            found  = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                if (key_valid === 1'b1) found = 1'b1;
            end
            exp_cnt = exp_cnt + 8'd1;
            n_checks++; if (!found) begin n_fail++; $display("FAIL wrap press %0d: key_valid never rose", p); end
            n_checks++; if (key_count !== exp_cnt) begin n_fail++; $display("FAIL wrap count %0d: got %0d want %0d", p, key_count, exp_cnt); end
            tick();
            n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL wrap valid_width %0d: got %b want 0", p, key_valid); end
            row_in = 4'b0000;
            found  = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                if (key_held === 1'b0) found = 1'b1;
            end
            n_checks++; if (!found) begin n_fail++; $display("FAIL wrap release %0d: key_held stayed 1", p); end
        end
        n_checks++; if (key_count !== 8'd0) begin n_fail++; $display("FAIL wrap final_count: got %0d want 0", key_count); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_debounce();
        wait_col(4'b0100, "midrst");
        row_in = 4'b0001;
        tick(); tick();            // E0
        tick();                    // one DEBOUNCE clock
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        row_in = 4'b0000;
        n_checks++; if (col_out !== 4'b0001) begin n_fail++; $display("FAIL midrst col_out: got %b want 0001", col_out); end
        n_checks++; if (key_code !== 4'd0) begin n_fail++; $display("FAIL midrst key_code: got %b want 0000", key_code); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL midrst key_held: got %b want 0", key_held); end
        n_checks++; if (key_count !== 8'd0) begin n_fail++; $display("FAIL midrst key_count: got %0d want 0", key_count); end
        for (int k = 0; k < 12; k++) begin
            n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst no_valid %0d: got %b want 0", k, key_valid); end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_bounce();
        test_wrap();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
